// File: rtl/rng_req_arbiter_pkg.sv
// Shared constants and types for the random-word request arbiter.
// Word width, FSM state type and a small modular-increment helper.
package rng_req_arbiter_pkg;

  localparam int RNG_W = 64;

  typedef enum logic {
    RUN,
    ALARM
  } rng_arb_state_t;

  function automatic int wrap_inc(input int v, input int n);
    return (v + 1) % n;
  endfunction

endpackage

// File: rtl/rng_req_arbiter_if.sv
// Bundle of random-word, request/grant and health signals for rng_req_arbiter.
// The slave modport is the arbiter side; master is the producer/consumer side.
interface rng_req_arbiter_if #(
  parameter int N_REQ = 4,
  parameter int DEPTH = 4
);
  import rng_req_arbiter_pkg::*;

  logic [RNG_W-1:0]           rand_num_i;
  logic                       rand_valid_i;
  logic [N_REQ-1:0]           req_i;
  logic [N_REQ-1:0]           gnt_o;
  logic [RNG_W-1:0]           data_o;
  logic                       alarm_o;
  logic                       alarm_clr_i;
  logic [$clog2(DEPTH):0]     fill_o;

  modport slave (
    input  rand_num_i, rand_valid_i, req_i, alarm_clr_i,
    output gnt_o, data_o, alarm_o, fill_o
  );

  modport master (
    output rand_num_i, rand_valid_i, req_i, alarm_clr_i,
    input  gnt_o, data_o, alarm_o, fill_o
  );

endinterface

// File: rtl/rng_req_arbiter_fifo.sv
// Synchronous FIFO of random words with flush; head word is visible combinationally.
// Pointers carry one extra wrap bit so full and empty are distinguishable.
module rng_req_arbiter_fifo
  import rng_req_arbiter_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   flush,
  input  logic                   push,
  input  logic [RNG_W-1:0]       push_data,
  input  logic                   pop,
  output logic [RNG_W-1:0]       head_data,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] DEPTH_C = (AW + 1)'(DEPTH);

  logic [RNG_W-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;

  always_ff @(posedge clk) begin
    if (!rst_n || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // Storage is not reset; only entries between the pointers are ever read.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr[AW-1:0]] <= push_data;
  end

  assign head_data = mem[rd_ptr[AW-1:0]];
  assign count     = wr_ptr - rd_ptr;
  assign full      = (count == DEPTH_C);
  assign empty     = (count == '0);

endmodule

// File: rtl/rng_req_arbiter.sv
// Shares a conditioned random word stream between N_REQ consumers, round-robin,
// behind a repetition-count health test that flushes and halts service on failure.
module rng_req_arbiter
  import rng_req_arbiter_pkg::*;
#(
  parameter int N_REQ     = 4,
  parameter int DEPTH     = 4,
  parameter int REP_LIMIT = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  rng_req_arbiter_if.slave   bus
);

  localparam int PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int REP_W = $clog2(REP_LIMIT + 1);
  localparam logic [REP_W-1:0] REP_MAX = REP_W'(REP_LIMIT);

  rng_arb_state_t     state_q, state_nxt;
  logic [REP_W-1:0]   rep_cnt, rep_nxt;
  logic [RNG_W-1:0]   last_word, last_nxt;
  logic [PTR_W-1:0]   rr_ptr, rr_nxt;
  logic [N_REQ-1:0]   gnt_q, gnt_nxt;
  logic [RNG_W-1:0]   data_q, data_nxt;

  logic               push, pop, flush, new_word;
  logic [RNG_W-1:0]   fifo_head;
  logic               fifo_full, fifo_empty;
  logic [$clog2(DEPTH):0] fifo_count;

  logic [N_REQ-1:0]   eligible;
  logic               win_found;
  logic [PTR_W-1:0]   win_idx;
  logic [PTR_W-1:0]   cand;

  rng_req_arbiter_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (flush),
    .push      (push),
    .push_data (bus.rand_num_i),
    .pop       (pop),
    .head_data (fifo_head),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  // A requester whose grant is on the output this cycle is skipped, so a held
  // level request cannot collect two words back to back.
  assign eligible = bus.req_i & ~gnt_q;

  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    cand      = '0;
    for (int k = 0; k < N_REQ; k++) begin
      cand = PTR_W'((int'(rr_ptr) + k) % N_REQ);
      if (!win_found && eligible[cand]) begin
        win_found = 1'b1;
        win_idx   = cand;
      end
    end
  end

  always_comb begin
    state_nxt = state_q;
    rep_nxt   = rep_cnt;
    last_nxt  = last_word;
    rr_nxt    = rr_ptr;
    gnt_nxt   = '0;
    data_nxt  = data_q;
    push      = 1'b0;
    pop       = 1'b0;
    flush     = 1'b0;
    new_word  = 1'b0;
    case (state_q)
      RUN: begin
        if (bus.alarm_clr_i) rep_nxt = '0;
        if (bus.rand_valid_i) begin
          if (bus.rand_num_i == last_word) begin
            if (!bus.alarm_clr_i && rep_cnt != REP_MAX) rep_nxt = rep_cnt + 1'b1;
          end else begin
            rep_nxt  = '0;
            last_nxt = bus.rand_num_i;
            new_word = 1'b1;
          end
        end
        // Tripping pre-empts any grant decision on the same edge.
        if (rep_nxt == REP_MAX) begin
          state_nxt = ALARM;
          flush     = 1'b1;
        end else begin
          if (!fifo_empty && win_found) begin
            pop              = 1'b1;
            gnt_nxt[win_idx] = 1'b1;
            data_nxt         = fifo_head;
            rr_nxt           = PTR_W'(wrap_inc(int'(win_idx), N_REQ));
          end
          push = new_word && (!fifo_full || pop);
        end
      end
      ALARM: begin
        if (bus.alarm_clr_i) begin
          state_nxt = RUN;
          rep_nxt   = '0;
        end
      end
      default: state_nxt = RUN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= RUN;
      rep_cnt   <= '0;
      last_word <= '0;
      rr_ptr    <= '0;
      gnt_q     <= '0;
      data_q    <= '0;
    end else begin
      state_q   <= state_nxt;
      rep_cnt   <= rep_nxt;
      last_word <= last_nxt;
      rr_ptr    <= rr_nxt;
      gnt_q     <= gnt_nxt;
      data_q    <= data_nxt;
    end
  end

  assign bus.gnt_o   = gnt_q;
  assign bus.data_o  = data_q;
  assign bus.alarm_o = (state_q == ALARM);
  assign bus.fill_o  = fifo_count;

endmodule

// File: tb/tb_rng_req_arbiter.sv
// Self-checking bench for rng_req_arbiter: directed scenarios plus random traffic
// compared against a queue-based reference model of the arbiter.
module tb_rng_req_arbiter;

  localparam int N_REQ     = 4;
  localparam int DEPTH     = 4;
  localparam int REP_LIMIT = 4;

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_errors;

  rng_req_arbiter_if #(.N_REQ(N_REQ), .DEPTH(DEPTH)) bus();

  rng_req_arbiter #(.N_REQ(N_REQ), .DEPTH(DEPTH), .REP_LIMIT(REP_LIMIT)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: buffered words in a queue, rules applied per clock edge.
  logic [63:0]      m_q[$];
  logic [63:0]      m_last;
  int               m_rep;
  bit               m_alarm;
  int               m_rr;
  logic [N_REQ-1:0] m_gnt;
  logic [63:0]      m_data;

  always @(posedge clk) begin : model
    logic [N_REQ-1:0] elig;
    int  size0;
    int  idx;
    bit  popped;
    bit  trip;
    bit  pushw;
    bit  found;
    elig = '0; size0 = 0; idx = 0; popped = 0; trip = 0; pushw = 0; found = 0;
    if (!rst_n) begin
      m_q.delete();
      m_last = '0; m_rep = 0; m_alarm = 0; m_rr = 0; m_gnt = '0; m_data = '0;
    end else if (m_alarm) begin
      m_gnt = '0;
      if (bus.alarm_clr_i) begin
        m_alarm = 0;
        m_rep   = 0;
      end
    end else begin
      if (bus.alarm_clr_i) m_rep = 0;
      if (bus.rand_valid_i) begin
        if (bus.rand_num_i == m_last) begin
          if (!bus.alarm_clr_i && m_rep < REP_LIMIT) m_rep = m_rep + 1;
        end else begin
          m_rep  = 0;
          m_last = bus.rand_num_i;
          pushw  = 1;
        end
      end
      trip  = (m_rep == REP_LIMIT);
      elig  = bus.req_i & ~m_gnt;
      size0 = m_q.size();
      m_gnt = '0;
      if (!trip && size0 > 0 && elig != '0) begin
        for (int k = 0; k < N_REQ; k++) begin
          if (!found && elig[(m_rr + k) % N_REQ]) begin
            found = 1;
            idx   = (m_rr + k) % N_REQ;
          end
        end
        m_gnt[idx] = 1'b1;
        m_data     = m_q.pop_front();
        m_rr       = (idx + 1) % N_REQ;
        popped     = 1;
      end
      if (trip) begin
        m_q.delete();
        m_alarm = 1;
      end else if (pushw && (size0 < DEPTH || popped)) begin
        m_q.push_back(bus.rand_num_i);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.rand_num_i   = '0;
    bus.rand_valid_i = 1'b0;
    bus.req_i        = '0;
    bus.alarm_clr_i  = 1'b0;
  endtask

  task automatic apply_reset();
    idle_inputs();
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  function automatic logic [63:0] fresh_word();
    logic [63:0] w;
    do w = {$urandom, $urandom}; while (w == m_last || w == '0);
    return w;
  endfunction

  task automatic test_reset();
    apply_reset();
    n_checks++;
    if (bus.gnt_o !== '0) begin n_errors++; $display("[TB] FAIL reset_gnt: got %b expected 0", bus.gnt_o); end
    n_checks++;
    if (bus.data_o !== '0) begin n_errors++; $display("[TB] FAIL reset_data: got %h expected 0", bus.data_o); end
    n_checks++;
    if (bus.alarm_o !== 1'b0) begin n_errors++; $display("[TB] FAIL reset_alarm: got %b expected 0", bus.alarm_o); end
    n_checks++;
    if (bus.fill_o !== '0) begin n_errors++; $display("[TB] FAIL reset_fill: got %0d expected 0", bus.fill_o); end
  endtask

  task automatic test_single_requester();
    logic [63:0]      w[3];
    logic [N_REQ-1:0] exp_g;
    apply_reset();
    for (int i = 0; i < 3; i++) begin
      w[i] = fresh_word();
      bus.rand_num_i = w[i]; bus.rand_valid_i = 1'b1;
      tick();
    end
    bus.rand_valid_i = 1'b0;
    n_checks++;
    if (bus.fill_o !== 3) begin n_errors++; $display("[TB] FAIL single_fill3: got %0d expected 3", bus.fill_o); end
    bus.req_i = 4'b0001;
    for (int c = 1; c <= 6; c++) begin
      tick();
      exp_g = (c % 2 == 1) ? 4'b0001 : 4'b0000;
      n_checks++;
      if (bus.gnt_o !== exp_g) begin n_errors++; $display("[TB] FAIL single_gnt c%0d: got %b expected %b", c, bus.gnt_o, exp_g); end
      if (c % 2 == 1) begin
        n_checks++;
        if (bus.data_o !== w[c/2]) begin n_errors++; $display("[TB] FAIL single_data c%0d: got %h expected %h", c, bus.data_o, w[c/2]); end
      end
    end
    bus.req_i = '0;
    n_checks++;
    if (bus.fill_o !== 0) begin n_errors++; $display("[TB] FAIL single_fill0: got %0d expected 0", bus.fill_o); end
  endtask

  task automatic test_fairness();
    logic [63:0]      w[4];
    logic [N_REQ-1:0] exp_g;
    apply_reset();
    for (int i = 0; i < 4; i++) begin
      w[i] = fresh_word();
      bus.rand_num_i = w[i]; bus.rand_valid_i = 1'b1;
      tick();
    end
    bus.rand_valid_i = 1'b0;
    n_checks++;
    if (bus.fill_o !== 4) begin n_errors++; $display("[TB] FAIL fair_fill4: got %0d expected 4", bus.fill_o); end
    bus.req_i = 4'b1111;
    for (int k = 0; k < 4; k++) begin
      tick();
      exp_g = 4'(1 << k);
      n_checks++;
      if (bus.gnt_o !== exp_g) begin n_errors++; $display("[TB] FAIL fair_gnt%0d: got %b expected %b", k, bus.gnt_o, exp_g); end
      n_checks++;
      if (bus.data_o !== w[k]) begin n_errors++; $display("[TB] FAIL fair_data%0d: got %h expected %h", k, bus.data_o, w[k]); end
      bus.req_i = bus.req_i & ~exp_g;
    end
    tick();
    n_checks++;
    if (bus.gnt_o !== '0) begin n_errors++; $display("[TB] FAIL fair_after: got %b expected 0", bus.gnt_o); end
    n_checks++;
    if (bus.fill_o !== 0) begin n_errors++; $display("[TB] FAIL fair_fill0: got %0d expected 0", bus.fill_o); end
  endtask

  task automatic test_health();
    logic [63:0] a;
    logic [63:0] b;
    a = 64'hA5A5_A5A5_A5A5_A5A5;
    apply_reset();
    for (int i = 1; i <= 5; i++) begin
      bus.rand_num_i = a; bus.rand_valid_i = 1'b1;
      tick();
      if (i == 1) begin
        n_checks++;
        if (bus.fill_o !== 1) begin n_errors++; $display("[TB] FAIL health_push: got %0d expected 1", bus.fill_o); end
      end
      if (i == 4) begin
        n_checks++;
        if (bus.alarm_o !== 1'b0) begin n_errors++; $display("[TB] FAIL health_early: got %b expected 0", bus.alarm_o); end
      end
    end
    n_checks++;
    if (bus.alarm_o !== 1'b1) begin n_errors++; $display("[TB] FAIL health_alarm: got %b expected 1", bus.alarm_o); end
    n_checks++;
    if (bus.fill_o !== 0) begin n_errors++; $display("[TB] FAIL health_flush: got %0d expected 0", bus.fill_o); end
    bus.req_i = 4'b1111;
    for (int i = 0; i < 3; i++) begin
      bus.rand_num_i = fresh_word();
      tick();
      n_checks++;
      if (bus.gnt_o !== '0 || bus.fill_o !== 0 || bus.alarm_o !== 1'b1) begin
        n_errors++;
        $display("[TB] FAIL health_halt%0d: got gnt=%b fill=%0d alarm=%b expected 0/0/1", i, bus.gnt_o, bus.fill_o, bus.alarm_o);
      end
    end
    bus.req_i = '0; bus.rand_valid_i = 1'b0;
    bus.alarm_clr_i = 1'b1;
    tick();
    bus.alarm_clr_i = 1'b0;
    n_checks++;
    if (bus.alarm_o !== 1'b0) begin n_errors++; $display("[TB] FAIL health_clr: got %b expected 0", bus.alarm_o); end
    bus.rand_num_i = a; bus.rand_valid_i = 1'b1;
    tick();
    n_checks++;
    if (bus.fill_o !== 0) begin n_errors++; $display("[TB] FAIL health_last_kept: got %0d expected 0", bus.fill_o); end
    b = fresh_word();
    bus.rand_num_i = b;
    tick();
    bus.rand_valid_i = 1'b0;
    n_checks++;
    if (bus.fill_o !== 1) begin n_errors++; $display("[TB] FAIL health_resume: got %0d expected 1", bus.fill_o); end
    bus.req_i = 4'b0001;
    tick();
    bus.req_i = '0;
    n_checks++;
    if (bus.gnt_o !== 4'b0001 || bus.data_o !== b) begin
      n_errors++;
      $display("[TB] FAIL health_grant: got %b/%h expected 0001/%h", bus.gnt_o, bus.data_o, b);
    end
  endtask

  task automatic test_full_simultaneous();
    logic [63:0]      w[4];
    logic [63:0]      exp_w[4];
    logic [63:0]      y;
    logic [N_REQ-1:0] exp_g;
    apply_reset();
    for (int i = 0; i < 4; i++) begin
      w[i] = fresh_word();
      bus.rand_num_i = w[i]; bus.rand_valid_i = 1'b1;
      tick();
    end
    bus.rand_num_i = fresh_word();
    tick();
    n_checks++;
    if (bus.fill_o !== 4) begin n_errors++; $display("[TB] FAIL full_drop: got %0d expected 4", bus.fill_o); end
    y = fresh_word();
    bus.rand_num_i = y; bus.req_i = 4'b0001;
    tick();
    bus.rand_valid_i = 1'b0;
    n_checks++;
    if (bus.gnt_o !== 4'b0001 || bus.data_o !== w[0]) begin
      n_errors++;
      $display("[TB] FAIL full_simul_gnt: got %b/%h expected 0001/%h", bus.gnt_o, bus.data_o, w[0]);
    end
    n_checks++;
    if (bus.fill_o !== 4) begin n_errors++; $display("[TB] FAIL full_simul_fill: got %0d expected 4", bus.fill_o); end
    exp_w[0] = w[1]; exp_w[1] = w[2]; exp_w[2] = w[3]; exp_w[3] = y;
    for (int c = 1; c <= 8; c++) begin
      tick();
      exp_g = (c % 2 == 0) ? 4'b0001 : 4'b0000;
      n_checks++;
      if (bus.gnt_o !== exp_g) begin n_errors++; $display("[TB] FAIL full_drain_gnt c%0d: got %b expected %b", c, bus.gnt_o, exp_g); end
      if (c % 2 == 0) begin
        n_checks++;
        if (bus.data_o !== exp_w[c/2-1]) begin n_errors++; $display("[TB] FAIL full_drain_data c%0d: got %h expected %h", c, bus.data_o, exp_w[c/2-1]); end
      end
    end
    n_checks++;
    if (bus.fill_o !== 0) begin n_errors++; $display("[TB] FAIL full_empty: got %0d expected 0", bus.fill_o); end
    bus.req_i = 4'b1111;
    for (int c = 0; c < 3; c++) begin
      tick();
      n_checks++;
      if (bus.gnt_o !== '0) begin n_errors++; $display("[TB] FAIL empty_nogrant%0d: got %b expected 0", c, bus.gnt_o); end
    end
    bus.req_i = '0;
  endtask

  task automatic test_reset_mid_stream();
    logic [63:0] w;
    apply_reset();
    for (int i = 0; i < 4; i++) begin
      bus.rand_num_i = fresh_word(); bus.rand_valid_i = 1'b1;
      tick();
    end
    bus.rand_valid_i = 1'b0;
    bus.req_i = 4'b0001;
    tick();
    n_checks++;
    if (bus.gnt_o !== 4'b0001 || bus.fill_o !== 3) begin
      n_errors++;
      $display("[TB] FAIL mid_pre: got gnt=%b fill=%0d expected 0001/3", bus.gnt_o, bus.fill_o);
    end
    rst_n = 1'b0;
    bus.req_i = 4'b0010;
    tick();
    rst_n = 1'b1;
    n_checks++;
    if (bus.gnt_o !== '0 || bus.fill_o !== 0 || bus.alarm_o !== 1'b0 || bus.data_o !== '0) begin
      n_errors++;
      $display("[TB] FAIL mid_reset: got gnt=%b fill=%0d alarm=%b data=%h expected 0/0/0/0", bus.gnt_o, bus.fill_o, bus.alarm_o, bus.data_o);
    end
    bus.req_i = '0;
    w = fresh_word();
    bus.rand_num_i = w; bus.rand_valid_i = 1'b1;
    tick();
    bus.rand_valid_i = 1'b0;
    bus.req_i = 4'b1111;
    tick();
    bus.req_i = '0;
    n_checks++;
    if (bus.gnt_o !== 4'b0001 || bus.data_o !== w) begin
      n_errors++;
      $display("[TB] FAIL mid_first_grant: got %b/%h expected 0001/%h", bus.gnt_o, bus.data_o, w);
    end
    bus.rand_num_i = 64'h1234_5678_9ABC_DEF0; bus.rand_valid_i = 1'b1;
    for (int i = 0; i < 5; i++) tick();
    bus.rand_valid_i = 1'b0;
    n_checks++;
    if (bus.alarm_o !== 1'b1) begin n_errors++; $display("[TB] FAIL mid_trip: got %b expected 1", bus.alarm_o); end
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    n_checks++;
    if (bus.alarm_o !== 1'b0) begin n_errors++; $display("[TB] FAIL mid_alarm_reset: got %b expected 0", bus.alarm_o); end
  endtask

  task automatic test_random();
    logic [63:0] pool[4];
    apply_reset();
    for (int i = 0; i < 4; i++) pool[i] = {$urandom, $urandom};
    for (int c = 0; c < 400; c++) begin
      bus.rand_valid_i = 1'($urandom_range(0, 1));
      bus.rand_num_i   = ($urandom_range(0, 1) == 1) ? m_last : pool[$urandom_range(0, 3)];
      bus.req_i        = 4'($urandom_range(0, 15));
      bus.alarm_clr_i  = ($urandom_range(0, 15) == 0);
      tick();
      n_checks++;
      if (bus.gnt_o !== m_gnt) begin n_errors++; $display("[TB] FAIL rand_gnt c%0d: got %b expected %b", c, bus.gnt_o, m_gnt); end
      n_checks++;
      if (bus.data_o !== m_data) begin n_errors++; $display("[TB] FAIL rand_data c%0d: got %h expected %h", c, bus.data_o, m_data); end
      n_checks++;
      if (bus.fill_o !== m_q.size()) begin n_errors++; $display("[TB] FAIL rand_fill c%0d: got %0d expected %0d", c, bus.fill_o, m_q.size()); end
      n_checks++;
      if (bus.alarm_o !== m_alarm) begin n_errors++; $display("[TB] FAIL rand_alarm c%0d: got %b expected %b", c, bus.alarm_o, m_alarm); end
    end
    idle_inputs();
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    rst_n    = 1'b0;
    idle_inputs();
    $display("[TB] starting rng_req_arbiter bench");
    test_reset();
    test_single_requester();
    test_fairness();
    test_health();
    test_full_simultaneous();
    test_reset_mid_stream();
    test_random();
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
